// File: rtl/pipeline_spi_command_master.sv
// SPI mode-0 master: one command at a time, up to MAX_BYTES per SS-low frame, MISO bytes returned on rsp_data.
// cmd_ready is high only in IDLE, so upstream stalls for the whole frame plus the SS gap.
module pipeline_spi_command_master #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4,
    parameter int SS_GAP    = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    output logic [8*MAX_BYTES-1:0] rsp_data,
    output logic                   rsp_valid,
    output logic                   cmd_error,
    output logic                   busy,
    output logic                   hw_spi_clk,
    output logic                   hw_spi_ss,
    output logic                   hw_spi_mosi,
    input  logic                   hw_spi_miso
);

    localparam int TOT_W   = 8 * MAX_BYTES;
    localparam int BIT_W   = $clog2(TOT_W + 1);
    localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [TOT_W-1:0] tx_q;
    logic [TOT_W-1:0] rx_q;
    logic [TOT_W-1:0] rsp_data_q;
    logic             ready_q;
    logic             busy_q;
    logic             rsp_valid_q;
    logic             cmd_error_q;
    logic             sclk_q;
    logic             ss_q;
    logic             mosi_q;

    logic             div_end;
    logic             gap_end;
    logic             last_bit;
    logic             len_bad;
    logic [BIT_W-1:0] frame_bits;
    logic [TOT_W-1:0] rx_aligned;

    assign div_end    = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign gap_end    = (cnt_q == CNT_W'(SS_GAP - 1));
    assign frame_bits = BIT_W'({len_q, 3'b000});
    assign last_bit   = (bit_cnt_q == frame_bits);
    assign len_bad    = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_BYTES));
    // rx fills from the LSB; shifting by the unused width puts byte 0 at the top and zeros the unsent slots
    assign rx_aligned = rx_q << (BIT_W'(TOT_W) - frame_bits);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_error_q <= 1'b0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            cmd_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        len_q     <= cmd_len;
                        rx_q      <= '0;
                        tx_q      <= cmd_data << 1;
                        if (len_bad) begin
                            cmd_error_q <= 1'b1;
                            state_q     <= S_GAP;
                        end else begin
                            ss_q    <= 1'b0;
                            mosi_q  <= cmd_data[TOT_W-1];
                            state_q <= S_SETUP;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                // SETUP and LOW both end by raising SCLK and sampling MISO
                S_SETUP, S_LOW: begin
                    if (div_end) begin
                        cnt_q     <= '0;
                        sclk_q    <= 1'b1;
                        rx_q      <= {rx_q[TOT_W-2:0], hw_spi_miso};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        state_q   <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (div_end) begin
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        if (last_bit) begin
                            state_q <= S_HOLD;
                        end else begin
                            mosi_q  <= tx_q[TOT_W-1];
                            tx_q    <= tx_q << 1;
                            state_q <= S_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (div_end) begin
                        cnt_q       <= '0;
                        ss_q        <= 1'b1;
                        mosi_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_aligned;
                        state_q     <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign cmd_error   = cmd_error_q;
    assign rsp_data    = rsp_data_q;
    assign hw_spi_clk  = sclk_q;
    assign hw_spi_ss   = ss_q;
    assign hw_spi_mosi = mosi_q;

endmodule

// File: tb/tb_pipeline_spi_command_master.sv
// Bench for pipeline_spi_command_master: directed and random frames against a byte-level reference model.
module tb_pipeline_spi_command_master;

    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 4;
    localparam int SS_GAP    = 4;
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);
    localparam int TOT       = 8 * MAX_BYTES;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [TOT-1:0]   cmd_data;
    logic [TOT-1:0]   rsp_data;
    logic             rsp_valid;
    logic             cmd_error;
    logic             busy;
    logic             hw_spi_clk;
    logic             hw_spi_ss;
    logic             hw_spi_mosi;
    logic             hw_spi_miso;

    pipeline_spi_command_master #(
        .CLK_DIV  (CLK_DIV),
        .MAX_BYTES(MAX_BYTES),
        .SS_GAP   (SS_GAP),
        .LEN_W    (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .cmd_error  (cmd_error),
        .busy       (busy),
        .hw_spi_clk (hw_spi_clk),
        .hw_spi_ss  (hw_spi_ss),
        .hw_spi_mosi(hw_spi_mosi),
        .hw_spi_miso(hw_spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: shifts out slv_reply MSB first, advancing on each SCLK fall; loop_en makes it a wire loopback
    logic           loop_en = 1'b0;
    logic [TOT-1:0] slv_reply = '0;
    int             slv_idx = 0;
    logic [TOT-1:0] slv_sh;
    assign slv_sh      = slv_reply << slv_idx;
    assign hw_spi_miso = loop_en ? hw_spi_mosi : slv_sh[TOT-1];

    always @(negedge hw_spi_clk or posedge hw_spi_ss) begin
        if (hw_spi_ss) slv_idx = 0;
        else           slv_idx = slv_idx + 1;
    end

    typedef struct {
        int ss_low; int sclk_hi; int rise; int ss_fall; int rsp;
        int err; int busy; int rdy_low; int glitch; int gap;
    } cnt_t;

    cnt_t           mon  = '{default: 0};
    cnt_t           base = '{default: 0};
    int             cyc = 0;
    int             ss_rise_cyc = 0;
    logic           prev_ss = 1'b1;
    logic           prev_sclk = 1'b0;
    logic [63:0]    mosi_bits = '0;
    logic [TOT-1:0] rsp_hist[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!hw_spi_ss) mon.ss_low++;
        if (hw_spi_clk) mon.sclk_hi++;
        if (hw_spi_clk && !prev_sclk) begin
            mon.rise++;
            mosi_bits = {mosi_bits[62:0], hw_spi_mosi};
        end
        if (hw_spi_clk && hw_spi_ss) mon.glitch++;
        if (!hw_spi_ss && prev_ss) begin
            mon.ss_fall++;
            mon.gap = cyc - ss_rise_cyc;
        end
        if (hw_spi_ss && !prev_ss) ss_rise_cyc = cyc;
        if (rsp_valid) begin
            mon.rsp++;
            rsp_hist.push_back(rsp_data);
        end
        if (cmd_error) mon.err++;
        if (busy) mon.busy++;
        if (!cmd_ready) mon.rdy_low++;
        prev_ss   = hw_spi_ss;
        prev_sclk = hw_spi_clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [TOT-1:0] model_rsp(input int len, input logic [TOT-1:0] src);
        return src & ~({TOT{1'b1}} >> (8 * len));
    endfunction

    task automatic issue(input string tag, input int len, input logic [TOT-1:0] data);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            step();
        end
        chk({tag, ".ready"}, 64'(ok), 64'd1);
        base      = mon;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_len   = LEN_W'($urandom);
        cmd_data  = TOT'($urandom);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        chk({tag, ".done"}, 64'(ok), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int len, input logic [TOT-1:0] data,
                               input logic [TOT-1:0] reply, input logic lp);
        int          n;
        int          ss_exp;
        logic [63:0] mask;
        logic [63:0] exp_mosi;
        n        = 8 * len;
        ss_exp   = CLK_DIV * (16 * len + 1);
        mask     = (64'd1 << n) - 64'd1;
        exp_mosi = 64'(data) >> (TOT - n);
        chk({tag, ".rises"},   64'(mon.rise - base.rise),       64'(n));
        chk({tag, ".mosi"},    mosi_bits & mask,                exp_mosi);
        chk({tag, ".ss_low"},  64'(mon.ss_low - base.ss_low),   64'(ss_exp));
        chk({tag, ".sclk_hi"}, 64'(mon.sclk_hi - base.sclk_hi), 64'(CLK_DIV * n));
        chk({tag, ".frames"},  64'(mon.ss_fall - base.ss_fall), 64'd1);
        chk({tag, ".rsp_cnt"}, 64'(mon.rsp - base.rsp),         64'd1);
        chk({tag, ".rsp"},     64'(rsp_data),                   64'(model_rsp(len, lp ? data : reply)));
        chk({tag, ".err"},     64'(mon.err - base.err),         64'd0);
        chk({tag, ".busy"},    64'(mon.busy - base.busy),       64'(ss_exp + SS_GAP));
        chk({tag, ".rdy_low"}, 64'(mon.rdy_low - base.rdy_low), 64'(ss_exp + SS_GAP));
        chk({tag, ".glitch"},  64'(mon.glitch - base.glitch),   64'd0);
    endtask

    task automatic run_frame(input string tag, input int len, input logic [TOT-1:0] data,
                             input logic [TOT-1:0] reply, input logic lp);
        loop_en   = lp;
        slv_reply = reply;
        issue(tag, len, data);
        wait_done(tag);
        check_frame(tag, len, data, reply, lp);
    endtask

    task automatic run_bad(input string tag, input int len);
        logic [TOT-1:0] prev;
        prev = rsp_data;
        issue(tag, len, TOT'($urandom));
        wait_done(tag);
        chk({tag, ".frames"},  64'(mon.ss_fall - base.ss_fall), 64'd0);
        chk({tag, ".err"},     64'(mon.err - base.err),         64'd1);
        chk({tag, ".rsp_cnt"}, 64'(mon.rsp - base.rsp),         64'd0);
        chk({tag, ".busy"},    64'(mon.busy - base.busy),       64'(SS_GAP));
        chk({tag, ".rdy_low"}, 64'(mon.rdy_low - base.rdy_low), 64'(SS_GAP));
        chk({tag, ".rsp_hold"}, 64'(rsp_data),                  64'(prev));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [TOT-1:0] d1;
        logic [TOT-1:0] d2;
        logic [TOT-1:0] r;
        int             len;
        bit             ok;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) step();
        chk("rst.ss",        64'(hw_spi_ss),   64'd1);
        chk("rst.sclk",      64'(hw_spi_clk),  64'd0);
        chk("rst.mosi",      64'(hw_spi_mosi), 64'd0);
        chk("rst.ready",     64'(cmd_ready),   64'd0);
        chk("rst.busy",      64'(busy),        64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid),   64'd0);
        chk("rst.cmd_error", 64'(cmd_error),   64'd0);
        chk("rst.rsp_data",  64'(rsp_data),    64'd0);
        rst = 1'b0;
        #1;
        chk("rel.ready_pre", 64'(cmd_ready), 64'd0);
        step();
        chk("rel.ready", 64'(cmd_ready), 64'd1);

        // Reset pulse while idle
        step();
        rst = 1'b1;
        #1;
        chk("idle_rst.ss",    64'(hw_spi_ss),   64'd1);
        chk("idle_rst.sclk",  64'(hw_spi_clk),  64'd0);
        chk("idle_rst.mosi",  64'(hw_spi_mosi), 64'd0);
        chk("idle_rst.ready", 64'(cmd_ready),   64'd0);
        step();
        rst = 1'b0;
        step();
        chk("idle_rst.ready_after", 64'(cmd_ready), 64'd1);

        run_frame("single", 1, 32'hA500_0000, '0, 1'b1);
        run_frame("multi", 4, 32'h0180_FF3C, 32'hDEAD_BEEF, 1'b0);

        run_bad("bad_len0", 0);
        run_bad("bad_len5", 5);
        run_bad("bad_len7", 7);

        // Two 1-byte commands with cmd_valid held high throughout
        loop_en = 1'b1;
        d1 = TOT'($urandom);
        d2 = TOT'($urandom);
        issue("b2b", 1, d1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(1);
        cmd_data  = d2;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        chk("b2b.second_ready", 64'(ok), 64'd1);
        step();
        cmd_valid = 1'b0;
        wait_done("b2b");
        chk("b2b.frames",  64'(mon.ss_fall - base.ss_fall), 64'd2);
        chk("b2b.rsp_cnt", 64'(mon.rsp - base.rsp),         64'd2);
        chk("b2b.err",     64'(mon.err - base.err),         64'd0);
        chk("b2b.gap",     64'(mon.gap),                    64'(SS_GAP + 1));
        chk("b2b.ss_low",  64'(mon.ss_low - base.ss_low),   64'(2 * CLK_DIV * 17));
        chk("b2b.rises",   64'(mon.rise - base.rise),       64'd16);
        chk("b2b.rsp1",    64'(rsp_hist[rsp_hist.size() - 2]), 64'(model_rsp(1, d1)));
        chk("b2b.rsp2",    64'(rsp_hist[rsp_hist.size() - 1]), 64'(model_rsp(1, d2)));

        // Reset in the middle of a 2-byte frame
        loop_en   = 1'b0;
        slv_reply = TOT'($urandom);
        issue("abort", 2, TOT'($urandom));
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (mon.rise - base.rise >= 10) begin ok = 1'b1; break; end
            step();
        end
        chk("abort.reached", 64'(ok), 64'd1);
        chk("abort.rises", 64'(mon.rise - base.rise), 64'd10);
        rst = 1'b1;
        #1;
        chk("abort.ss",        64'(hw_spi_ss),  64'd1);
        chk("abort.sclk",      64'(hw_spi_clk), 64'd0);
        chk("abort.rsp_valid", 64'(rsp_valid),  64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("abort.rsp_cnt",  64'(mon.rsp - base.rsp), 64'd0);
        chk("abort.rsp_data", 64'(rsp_data),           64'd0);
        chk("abort.ready",    64'(cmd_ready),          64'd1);
        run_frame("after_abort", 1, TOT'($urandom), TOT'($urandom), 1'b0);

        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, MAX_BYTES);
            d1  = TOT'($urandom);
            r   = TOT'($urandom);
            run_frame($sformatf("rand%0d", k), len, d1, r, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
